// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and helpers for the UART transmit arbiter.
//               Holds the FSM state encoding, the tag nibble and the
//               round-robin pointer wrap function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    // Arbiter FSM states; tag states are only reachable with UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_TAG_START = 3'd2,
        ST_TAG_WAIT  = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT      = 3'd5,
        ST_GAP       = 3'd6
    } arb_state_e;

    // Upper nibble of the tag byte sent ahead of each payload
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    // Index following idx in a ring of n entries
    function automatic int unsigned ptr_wrap(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin requester selection. Searches from the rotating
//               pointer, latches the winner on lock_i and advances the
//               pointer past the latched winner on accept_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               lock_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;

    // First valid requester at or after the pointer, wrapping around the ring
    always_comb begin : p_search
        logic [IDX_W:0] cand;
        logic           found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                win_idx                 = cand[IDX_W-1:0];
                win_oh[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    // Latch the winner on lock, rotate priority past it on accept
    always_comb begin
        gnt_d = gnt_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        if (lock_i) begin
            gnt_d = win_oh;
            idx_d = win_idx;
        end
        if (accept_i) begin
            ptr_d = IDX_W'(ptr_wrap(32'(idx_q), NUM_REQ));
        end
    end

    // Grant and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            gnt_q <= '0;
            idx_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            idx_q <= idx_d;
        end
    end

    assign gnt_o = gnt_q;
    assign idx_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ byte producers.
//               Round-robin grant, byte capture, tx_start pulse, wait for
//               tx_done, inter-frame gap, then re-arbitrate.
//               Optional macro UART_ARB_TAG_EN: each payload byte is preceded
//               by a tag byte {TAG_NIBBLE, grant index}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = 8,
    parameter  int GAP_CYCLES = 2,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_busy_i,
    input  logic                      tx_done_i,
    output logic [IDX_W-1:0]          grant_id_o,
    output logic                      arb_busy_o
);

    // Gap counter runs 0..GAP_CYCLES-1 while in GAP
    localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e         state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic               lock, accept;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [DATA_W-1:0]  sel_data;
`ifdef UART_ARB_TAG_EN
    logic [DATA_W-1:0]  payload_q, payload_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid_i),
        .lock_i   (lock),
        .accept_i (accept),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx)
    );

    // Byte offered by the latched winner
    assign sel_data = req_data_i[arb_idx*DATA_W +: DATA_W];

    // Next-state, datapath updates and pulse outputs
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        lock        = 1'b0;
        accept      = 1'b0;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
`ifdef UART_ARB_TAG_EN
        payload_d   = payload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Winner is frozen here so a late drop of valid cannot change it
                if (|req_valid_i && !tx_busy_i) begin
                    lock    = 1'b1;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                req_ready_o = arb_gnt;
                accept      = 1'b1;
                grant_id_d  = arb_idx;
`ifdef UART_ARB_TAG_EN
                payload_d   = sel_data;
                tx_data_d   = DATA_W'({TAG_NIBBLE, 4'(arb_idx)});
                state_d     = ST_TAG_START;
`else
                tx_data_d   = sel_data;
                state_d     = ST_START;
`endif
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_START: begin
                tx_start_o = 1'b1;
                state_d    = ST_TAG_WAIT;
            end
            ST_TAG_WAIT: begin
                // Payload follows the tag with no gap
                if (tx_done_i) begin
                    tx_data_d = payload_q;
                    state_d   = ST_START;
                end
            end
`endif
            ST_START: begin
                tx_start_o = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any captured byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
`ifdef UART_ARB_TAG_EN
            payload_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
`ifdef UART_ARB_TAG_EN
            payload_q  <= payload_d;
`endif
        end
    end

    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_id_q;
    assign arb_busy_o = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with a small UART TX
//               model that returns tx_busy/tx_done and collects sent bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id_o;
    logic        arb_busy_o;
    logic        force_busy;

    int total = 0;
    int bad   = 0;
    int rd    = 0;

    // UART TX model state
    logic [3:0] cnt;
    logic [7:0] cap;
    int         cyc = 0;
    int         stab_bad = 0;
    logic [7:0] rx_q[$];
    int         st_cyc[$];
    int         dn_cyc[$];
    logic [3:0] gq[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_busy_i   (tx_busy),
        .tx_done_i   (tx_done),
        .grant_id_o  (grant_id_o),
        .arb_busy_o  (arb_busy_o)
    );

    assign tx_busy = (cnt != 4'd0) | force_busy;

    // 10-cycle frame; byte delivered to rx_q when the frame completes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            tx_done <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            tx_done <= 1'b0;
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) tx_done <= 1'b1;
            end else if (tx_start_o) begin
                cnt <= 4'd10;
                cap <= tx_data_o;
                st_cyc.push_back(cyc);
            end
            if (tx_done) begin
                dn_cyc.push_back(cyc);
                rx_q.push_back(cap);
                if (tx_data_o !== cap) stab_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic logic [3:0] gq_at(input int i);
        return (i < gq.size()) ? gq[i] : 4'hx;
    endfunction

    task automatic expect_byte(input string tag, input int id, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
        chk({tag, "_tag"}, 32'(rx_at(rd)), 32'({4'hA, 4'(id)}));
        rd++;
`endif
        chk(tag, 32'(rx_at(rd)), 32'(b));
        rd++;
    endtask

    // Requesters drop valid on their ready pulse; ends once everything drained
    task automatic run_idle(input string tag);
        bit done_f;
        done_f = 1'b0;
        for (int n = 0; n < 400 && !done_f; n++) begin
            @(negedge clk);
            if (req_ready_o != 4'd0) begin
                gq.push_back(req_ready_o);
                req_valid = req_valid & ~req_ready_o;
            end
            if (!arb_busy_o && req_valid == 4'd0 && !tx_busy) done_f = 1'b1;
        end
        chk({tag, "_timeout"}, 32'(done_f), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int bs, bd, gbase;
        logic [3:0] seen;
        int pulses;

        rst_n      = 1'b0;
        req_valid  = 4'd0;
        req_data   = {8'hC7, 8'hFF, 8'hA3, 8'h00};
        force_busy = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(arb_busy_o), 32'd0);
        chk("rst_start", 32'(tx_start_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_data",  32'(tx_data_o), 32'd0);
        chk("rst_gid",   32'(grant_id_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single request from requester 1
        req_data[15:8] = 8'h5E;
        req_valid      = 4'b0010;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready_o), 32'b0010);
        chk("t1_nostart", 32'(tx_start_o), 32'd0);
        req_valid = 4'd0;
        @(negedge clk);
        chk("t1_start", 32'(tx_start_o), 32'd1);
        chk("t1_ready_off", 32'(req_ready_o), 32'd0);
`ifdef UART_ARB_TAG_EN
        chk("t1_txdata", 32'(tx_data_o), 32'hA1);
`else
        chk("t1_txdata", 32'(tx_data_o), 32'h5E);
`endif
        @(negedge clk);
        chk("t1_start_off", 32'(tx_start_o), 32'd0);
        run_idle("t1");
        expect_byte("t1_rx", 1, 8'h5E);
        chk("t1_gid", 32'(grant_id_o), 32'd1);
        req_data[15:8] = 8'hA3;

        // Reset to bring the pointer back to 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: all four valid, sent in index order with fixed spacing
        bs = st_cyc.size();
        bd = dn_cyc.size();
        req_valid = 4'b1111;
        run_idle("t2");
        expect_byte("t2_rx0", 0, 8'h00);
        expect_byte("t2_rx1", 1, 8'hA3);
        expect_byte("t2_rx2", 2, 8'hFF);
        expect_byte("t2_rx3", 3, 8'hC7);
        chk("t2_gid", 32'(grant_id_o), 32'd3);
`ifndef UART_ARB_TAG_EN
        for (int k = 0; k < 3; k++) begin
            if (st_cyc.size() > bs + k + 1 && dn_cyc.size() > bd + k)
                chk("t2_spacing", st_cyc[bs+k+1] - dn_cyc[bd+k], GAP + 3);
            else
                chk("t2_spacing_missing", 32'd0, 32'd1);
        end
`endif

        // 3: requester 0 stays valid, requester 2 must be served next
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t3_ready0", 32'(req_ready_o), 32'b0001);
        req_valid = 4'b0101;
        gbase = gq.size();
        run_idle("t3");
        chk("t3_next", 32'(gq_at(gbase)), 32'b0100);
        chk("t3_then", 32'(gq_at(gbase + 1)), 32'b0001);
        expect_byte("t3_rx0", 0, 8'h00);
        expect_byte("t3_rx1", 2, 8'hFF);
        expect_byte("t3_rx2", 0, 8'h00);

        // 4: transmitter busy blocks acceptance
        force_busy = 1'b1;
        req_valid  = 4'b0001;
        seen       = 4'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | req_ready_o;
        end
        chk("t4_blocked", 32'(seen), 32'd0);
        chk("t4_idle", 32'(arb_busy_o), 32'd0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("t4_ready", 32'(req_ready_o), 32'b0001);
        req_valid = 4'd0;
        run_idle("t4");
        expect_byte("t4_rx", 0, 8'h00);

        // 5: reset while waiting for frame completion
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_ready2", 32'(req_ready_o), 32'b0100);
        req_valid = 4'b1010;
        repeat (4) @(negedge clk);
        chk("t5_inflight", 32'(arb_busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy",  32'(arb_busy_o), 32'd0);
        chk("t5_start", 32'(tx_start_o), 32'd0);
        chk("t5_gid",   32'(grant_id_o), 32'd0);
        chk("t5_data",  32'(tx_data_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rearb", 32'(req_ready_o), 32'b0010);
        req_valid = 4'b1000;
        run_idle("t5");
        expect_byte("t5_rx0", 1, 8'hA3);
        expect_byte("t5_rx1", 3, 8'hC7);

`ifdef UART_ARB_TAG_EN
        // 6: tag byte precedes payload, single accept pulse
        gbase     = gq.size();
        req_valid = 4'b1000;
        run_idle("t6");
        pulses = gq.size() - gbase;
        chk("t6_pulses", 32'(pulses), 32'd1);
        expect_byte("t6_rx", 3, 8'hC7);
`endif

        chk("rx_count", 32'(rx_q.size()), 32'(rd));
        chk("tx_data_stable", 32'(stab_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
